// File: rtl/connect4_pkg.sv
// rtl/connect4_pkg.sv - shared board sizes, controller states and winner codes
// Purpose: common types and constants for the Connect4 turn controller slice.
// Ports: none (package).
package connect4_pkg;

   localparam int ROWS      = 6;
   localparam int COLS      = 7;
   localparam int MAX_MOVES = ROWS * COLS;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_TURN      = 3'd1,
      S_AUTO      = 3'd2,
      S_CHECK     = 3'd3,
      S_GAME_OVER = 3'd4
   } ctrl_state_t;

   localparam logic [1:0] W_NONE = 2'b00;
   localparam logic [1:0] W_P0   = 2'b01;
   localparam logic [1:0] W_P1   = 2'b10;
   localparam logic [1:0] W_DRAW = 2'b11;

endpackage

// File: rtl/turn_timer.sv
// rtl/turn_timer.sv - per-turn prescaler plus seconds down-counter
// Purpose: counts clk cycles into seconds and counts the turn down to zero.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   load         reload sec_left=TURN_SECS and clear the prescaler
//   run          advance the prescaler this cycle
//   sec_left     seconds remaining (registered)
//   expire       combinational: this cycle's wrap takes sec_left from 1 to 0
module turn_timer #(
   parameter int CYCLES_PER_SEC = 50_000_000,
   parameter int TURN_SECS      = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       run,
   output logic [3:0] sec_left,
   output logic       expire
);

   localparam int             PW     = $clog2(CYCLES_PER_SEC);
   localparam logic [PW-1:0]  P_LAST = PW'(CYCLES_PER_SEC - 1);

   logic [PW-1:0] prescaler;
   logic          wrap;

   assign wrap   = (prescaler == P_LAST);
   assign expire = run && wrap && (sec_left == 4'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         prescaler <= '0;
         sec_left  <= 4'd0;
      end else if (load) begin
         prescaler <= '0;
         sec_left  <= 4'(TURN_SECS);
      end else if (run) begin
         if (wrap) begin
            prescaler <= '0;
            // hold at zero rather than wrapping round to 15
            if (sec_left != 4'd0)
               sec_left <= sec_left - 4'd1;
         end else begin
            prescaler <= prescaler + 1'b1;
         end
      end
   end

endmodule

// File: rtl/connect4_turn_controller.sv
// rtl/connect4_turn_controller.sv - Connect4 turn sequencer, timeout and result latch
// Purpose: gates the player unit, times each turn, forces an automatic move on
// timeout, triggers the win checker after each move and latches the result.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   start, FT, check_done, win      game start, turn finished, checker result
//   enable, jugador                 player unit enable and current player
//   auto_move, check_start          single-cycle command pulses
//   game_over, winner               final result (00 none, 01 p0, 10 p1, 11 draw)
//   move_count, sec_left            tokens placed, seconds left in this turn
module connect4_turn_controller #(
   parameter int   CYCLES_PER_SEC = 50_000_000,
   parameter int   TURN_SECS      = 10,
   parameter int   MAX_MOVES      = connect4_pkg::MAX_MOVES,
   parameter logic FIRST_PLAYER   = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       FT,
   input  logic       check_done,
   input  logic       win,
   output logic       enable,
   output logic       jugador,
   output logic       auto_move,
   output logic       check_start,
   output logic       game_over,
   output logic [1:0] winner,
   output logic [5:0] move_count,
   output logic [3:0] sec_left
);

   import connect4_pkg::*;

   localparam logic [5:0] MC_MAX = 6'(MAX_MOVES);

   ctrl_state_t state;
   logic        start_ok;
   logic        next_turn;
   logic        tmr_load;
   logic        tmr_run;
   logic        tmr_expire;

   assign start_ok  = start && ((state == S_IDLE) || (state == S_GAME_OVER));
   assign next_turn = (state == S_CHECK) && check_done && !win && (move_count != MC_MAX);
   assign tmr_load  = start_ok || next_turn;
   // FT freezes the timer on its own edge so a simultaneous wrap cannot expire
   assign tmr_run   = (state == S_TURN) && !FT;

   turn_timer #(
      .CYCLES_PER_SEC (CYCLES_PER_SEC),
      .TURN_SECS      (TURN_SECS)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .run      (tmr_run),
      .sec_left (sec_left),
      .expire   (tmr_expire)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         enable      <= 1'b0;
         jugador     <= FIRST_PLAYER;
         auto_move   <= 1'b0;
         check_start <= 1'b0;
         game_over   <= 1'b0;
         winner      <= W_NONE;
         move_count  <= 6'd0;
      end else begin
         auto_move   <= 1'b0;
         check_start <= 1'b0;
         case (state)
            S_IDLE, S_GAME_OVER: begin
               if (start_ok) begin
                  state      <= S_TURN;
                  enable     <= 1'b1;
                  jugador    <= FIRST_PLAYER;
                  game_over  <= 1'b0;
                  winner     <= W_NONE;
                  move_count <= 6'd0;
               end
            end
            S_TURN, S_AUTO: begin
               if (FT) begin
                  state       <= S_CHECK;
                  enable      <= 1'b0;
                  check_start <= 1'b1;
                  if (move_count != MC_MAX)
                     move_count <= move_count + 6'd1;
               end else if ((state == S_TURN) && tmr_expire) begin
                  state     <= S_AUTO;
                  auto_move <= 1'b1;
               end
            end
            S_CHECK: begin
               if (check_done) begin
                  if (win) begin
                     state     <= S_GAME_OVER;
                     game_over <= 1'b1;
                     winner    <= jugador ? W_P1 : W_P0;
                  end else if (move_count == MC_MAX) begin
                     state     <= S_GAME_OVER;
                     game_over <= 1'b1;
                     winner    <= W_DRAW;
                  end else begin
                     state   <= S_TURN;
                     enable  <= 1'b1;
                     jugador <= ~jugador;
                  end
               end
            end
            default: begin
               state  <= S_IDLE;
               enable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_connect4_turn_controller.sv
// tb/tb_connect4_turn_controller.sv - self-checking bench for connect4_turn_controller
module tb_connect4_turn_controller;

   localparam int CPS = 4;
   localparam int TS  = 3;
   localparam int MM  = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0, start = 1'b0, FT = 1'b0, check_done = 1'b0, win = 1'b0;
   logic       enable, jugador, auto_move, check_start, game_over;
   logic [1:0] winner;
   logic [5:0] move_count;
   logic [3:0] sec_left;

   int vectors     = 0;
   int miscompares = 0;

   connect4_turn_controller #(
      .CYCLES_PER_SEC (CPS),
      .TURN_SECS      (TS),
      .MAX_MOVES      (MM),
      .FIRST_PLAYER   (1'b0)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .FT          (FT),
      .check_done  (check_done),
      .win         (win),
      .enable      (enable),
      .jugador     (jugador),
      .auto_move   (auto_move),
      .check_start (check_start),
      .game_over   (game_over),
      .winner      (winner),
      .move_count  (move_count),
      .sec_left    (sec_left)
   );

   always #5 clk = ~clk;

   // Reference model: game phases and elapsed cycles within the turn
   localparam int PH_IDLE = 0, PH_PLAY = 1, PH_CHK = 2, PH_OVER = 3;
   int m_phase = PH_IDLE, m_elapsed = 0, m_player = 0, m_moves = 0, m_winner = 0, m_sec_frozen = 0;
   bit m_timedout = 0, m_auto = 0, m_cs = 0;

   function automatic int model_sec();
      if (m_phase != PH_PLAY) return 0;
      if (m_timedout) return 0;
      return TS - m_elapsed / CPS;
   endfunction

   task automatic model_step(input bit r, s, f, c, w);
      m_auto = 0;
      m_cs   = 0;
      if (r) begin
         m_phase = PH_IDLE; m_player = 0; m_moves = 0; m_winner = 0;
         m_elapsed = 0; m_timedout = 0;
      end else begin
         case (m_phase)
            PH_IDLE, PH_OVER: if (s) begin
               m_phase = PH_PLAY; m_player = 0; m_moves = 0; m_winner = 0;
               m_elapsed = 0; m_timedout = 0;
            end
            PH_PLAY: begin
               if (f) begin
                  m_phase = PH_CHK;
                  m_cs    = 1;
                  if (m_moves < MM) m_moves++;
               end else if (!m_timedout) begin
                  m_elapsed++;
                  if (m_elapsed == TS * CPS) begin
                     m_timedout = 1;
                     m_auto     = 1;
                  end
               end
            end
            PH_CHK: if (c) begin
               if (w) begin
                  m_phase = PH_OVER; m_winner = m_player ? 2 : 1;
               end else if (m_moves == MM) begin
                  m_phase = PH_OVER; m_winner = 3;
               end else begin
                  m_phase = PH_PLAY; m_player ^= 1; m_elapsed = 0; m_timedout = 0;
               end
            end
            default: m_phase = PH_IDLE;
         endcase
      end
   endtask

   function automatic logic [16:0] dut_vec();
      return {enable, jugador, auto_move, check_start, game_over, winner, move_count, sec_left};
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      logic [16:0] exp, mask;
      exp = {m_phase == PH_PLAY, 1'(m_player), m_auto, m_cs, m_phase == PH_OVER,
             2'(m_winner), 6'(m_moves), 4'(model_sec())};
      // seconds are only specified while idle or playing
      mask = (m_phase == PH_CHK || m_phase == PH_OVER) ? 17'h1FFF0 : 17'h1FFFF;
      check("model", dut_vec() & mask, exp & mask);
   endtask

   task automatic step(input bit r, s, f, c, w);
      reset = r; start = s; FT = f; check_done = c; win = w;
      @(posedge clk);
      #1;
      model_step(r, s, f, c, w);
      model_check();
   endtask

   typedef struct {
      bit r, s, f, c, w;
      bit en, j, am, cs, go;
      int wn, mc, sec;   // sec==15 means not checked
   } vec_t;

   vec_t tbl[$];

   task automatic addv(input bit r, s, f, c, w, input bit en, j, am, cs, go,
                       input int wn, mc, sec);
      vec_t v;
      v.r = r; v.s = s; v.f = f; v.c = c; v.w = w;
      v.en = en; v.j = j; v.am = am; v.cs = cs; v.go = go;
      v.wn = wn; v.mc = mc; v.sec = sec;
      tbl.push_back(v);
   endtask

   initial begin
      int n;
      logic [16:0] exp, mask;

      // reset mid-TURN
      addv(1,0,0,0,0, 0,0,0,0,0, 0,0,0);
      addv(0,1,0,0,0, 1,0,0,0,0, 0,0,3);
      addv(0,0,0,0,0, 1,0,0,0,0, 0,0,3);
      addv(0,0,0,0,0, 1,0,0,0,0, 0,0,3);
      addv(1,0,0,0,0, 0,0,0,0,0, 0,0,0);
      // start, FT after 5 cycles, check_done without win
      addv(0,1,0,0,0, 1,0,0,0,0, 0,0,3);
      addv(0,0,0,0,0, 1,0,0,0,0, 0,0,3);
      addv(0,0,0,0,0, 1,0,0,0,0, 0,0,3);
      addv(0,0,0,0,0, 1,0,0,0,0, 0,0,3);
      addv(0,0,0,0,0, 1,0,0,0,0, 0,0,2);
      addv(0,0,0,0,0, 1,0,0,0,0, 0,0,2);
      addv(0,0,1,0,0, 0,0,0,1,0, 0,1,2);
      addv(0,0,0,0,0, 0,0,0,0,0, 0,1,2);
      addv(0,0,0,1,0, 1,1,0,0,0, 0,1,3);
      // remaining turns to a draw
      addv(0,0,1,0,0, 0,1,0,1,0, 0,2,3);
      addv(0,0,0,1,0, 1,0,0,0,0, 0,2,3);
      addv(0,0,1,0,0, 0,0,0,1,0, 0,3,3);
      addv(0,0,0,1,0, 1,1,0,0,0, 0,3,3);
      addv(0,0,1,0,0, 0,1,0,1,0, 0,4,3);
      addv(0,0,0,1,0, 0,1,0,0,1, 3,4,15);
      // strays in GAME_OVER, then restart
      addv(0,0,1,0,0, 0,1,0,0,1, 3,4,15);
      addv(0,0,0,1,1, 0,1,0,0,1, 3,4,15);
      addv(0,1,0,0,0, 1,0,0,0,0, 0,0,3);
      // four turns, win on the last one by player1
      addv(0,0,1,0,0, 0,0,0,1,0, 0,1,3);
      addv(0,0,0,1,0, 1,1,0,0,0, 0,1,3);
      addv(0,0,1,0,0, 0,1,0,1,0, 0,2,3);
      addv(0,0,0,1,0, 1,0,0,0,0, 0,2,3);
      addv(0,0,1,0,0, 0,0,0,1,0, 0,3,3);
      addv(0,0,0,1,0, 1,1,0,0,0, 0,3,3);
      addv(0,0,1,0,0, 0,1,0,1,0, 0,4,3);
      addv(0,0,0,1,1, 0,1,0,0,1, 2,4,15);
      addv(0,0,1,0,0, 0,1,0,0,1, 2,4,15);
      // strays in IDLE, start/check_done ignored in TURN
      addv(1,0,0,0,0, 0,0,0,0,0, 0,0,0);
      addv(0,0,1,0,0, 0,0,0,0,0, 0,0,0);
      addv(0,0,0,1,1, 0,0,0,0,0, 0,0,0);
      addv(0,1,0,0,0, 1,0,0,0,0, 0,0,3);
      addv(0,1,0,0,0, 1,0,0,0,0, 0,0,3);
      addv(0,0,0,1,1, 1,0,0,0,0, 0,0,3);

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].c, tbl[i].w);
         exp = {tbl[i].en, tbl[i].j, tbl[i].am, tbl[i].cs, tbl[i].go,
                2'(tbl[i].wn), 6'(tbl[i].mc), 4'(tbl[i].sec)};
         mask = (tbl[i].sec == 15) ? 17'h1FFF0 : 17'h1FFFF;
         check($sformatf("table[%0d]", i), dut_vec() & mask, exp & mask);
      end

      // timeout: auto_move 12 cycles after entry, then AUTO until FT
      step(1,0,0,0,0);
      step(0,1,0,0,0);
      n = -1;
      for (int i = 1; i <= 20 && n < 0; i++) begin
         step(0,0,0,0,0);
         if (auto_move) n = i;
      end
      check("auto_latency", n, 12);
      check("auto_enable", enable, 1);
      check("auto_sec", sec_left, 0);
      for (int i = 0; i < 3; i++) step(0,0,0,0,0);
      check("auto_no_repeat", auto_move, 0);
      step(0,0,1,0,0);
      check("auto_ft_check_start", {enable, check_start}, 2'b01);
      check("auto_ft_mc", move_count, 1);
      step(0,0,0,1,0);
      check("auto_next_player", {enable, jugador, sec_left}, {2'b11, 4'd3});

      // FT on the same edge as the expiring wrap
      step(1,0,0,0,0);
      step(0,1,0,0,0);
      for (int i = 0; i < 11; i++) step(0,0,0,0,0);
      check("pre_wrap_sec", sec_left, 1);
      step(0,0,1,0,0);
      check("ft_beats_timeout", {auto_move, check_start, enable}, 3'b010);
      step(0,0,0,0,0);
      check("ft_beats_timeout_after", {auto_move, enable}, 2'b00);

      // randomized traffic against the model
      step(1,0,0,0,0);
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 5) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
